// File: rtl/bit_sync_edge_filter.sv
// bit_sync_edge_filter: per-channel sync chain, glitch filter (BIT_SYNC_EDGE_FILTER_EN) and edge pulses
module bit_sync_edge_filter #(
  parameter int   WIDTH         = 8,
  parameter int   STAGES        = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic             clkB,
  input  logic             rstB,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);
  if (WIDTH < 1 || STAGES < 2 || FILTER_CYCLES < 1) begin : g_bad_params
    $error("bit_sync_edge_filter: illegal parameters");
  end
  logic [WIDTH-1:0] s [STAGES];
  logic [WIDTH-1:0] s_last;
  logic [WIDTH-1:0] upd;
  assign s_last = s[STAGES-1];
  always_ff @(posedge clkB) begin
    s[0] <= rstB ? {WIDTH{RESET_VAL}} : async_in;
    for (int k = 1; k < STAGES; k++) s[k] <= rstB ? {WIDTH{RESET_VAL}} : s[k-1];
  end
`ifdef BIT_SYNC_EDGE_FILTER_EN
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  logic [CW-1:0] cnt [WIDTH];
  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++) upd[i] = s_last[i] != sync_out[i] && cnt[i] == CW'(FILTER_CYCLES - 1);
  end
  // any cycle agreeing with the accepted level restarts the persistence count
  always_ff @(posedge clkB)
    for (int i = 0; i < WIDTH; i++)
      cnt[i] <= (rstB || s_last[i] == sync_out[i] || upd[i]) ? '0 : cnt[i] + CW'(1);
`else
  assign upd = s_last ^ sync_out;
`endif
  always_ff @(posedge clkB) begin
    sync_out   <= rstB ? {WIDTH{RESET_VAL}} : sync_out ^ upd;
    rise_pulse <= rstB ? '0 : upd & s_last;
    fall_pulse <= rstB ? '0 : upd & ~s_last;
    any_change <= !rstB && |upd;
  end
endmodule

// File: tb/tb_bit_sync_edge_filter.sv
// tb_bit_sync_edge_filter: randomized and directed checks against a sliding-window reference model
module tb_bit_sync_edge_filter;
  localparam int   W  = 8;
  localparam int   S  = 2;
  localparam logic RV = 1'b0;
`ifdef BIT_SYNC_EDGE_FILTER_EN
  localparam int F = 4;
`else
  localparam int F = 1;
`endif
  localparam int LAT = S + F;

  logic clkB = 1'b0;
  logic rstB;
  logic [W-1:0] async_in;
  logic [W-1:0] sync_out, rise_pulse, fall_pulse;
  logic any_change;
  int errors = 0;
  int checks = 0;

  bit_sync_edge_filter #(.WIDTH(W), .STAGES(S), .FILTER_CYCLES(4), .RESET_VAL(RV)) dut (
    .clkB(clkB), .rstB(rstB), .async_in(async_in), .sync_out(sync_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .any_change(any_change)
  );

  always #5 clkB = ~clkB;

  // Reference: a level is accepted once the delayed input has differed from it for F consecutive edges.
  logic [W-1:0] m_pipe [S];
  logic [W-1:0] m_hist [F];
  logic [W-1:0] m_filt, m_rise, m_fall, m_sl, m_upd;
  logic m_any;
  logic [3*W:0] m_vec, d_vec;
  always_comb begin
    m_sl = m_pipe[S-1];
    m_upd = m_sl ^ m_filt;
    for (int j = 0; j < F - 1; j++) m_upd = m_upd & (m_hist[j] ^ m_filt);
    m_vec = {m_filt, m_rise, m_fall, m_any};
    d_vec = {sync_out, rise_pulse, fall_pulse, any_change};
  end
  always @(posedge clkB) begin
    if (rstB) begin
      for (int k = 0; k < S; k++) m_pipe[k] <= {W{RV}};
      for (int j = 0; j < F; j++) m_hist[j] <= {W{RV}};
      m_filt <= {W{RV}};
      m_rise <= '0;
      m_fall <= '0;
      m_any  <= 1'b0;
    end else begin
      m_pipe[0] <= async_in;
      for (int k = 1; k < S; k++) m_pipe[k] <= m_pipe[k-1];
      m_hist[0] <= m_sl;
      for (int j = 1; j < F; j++) m_hist[j] <= m_hist[j-1];
      m_filt <= m_filt ^ m_upd;
      m_rise <= m_upd & m_sl;
      m_fall <= m_upd & ~m_sl;
      m_any  <= |m_upd;
    end
  end

  task automatic cyc();
    @(posedge clkB);
    @(negedge clkB);
  endtask

  task automatic test_idle(input int n);
    async_in = '0;
    for (int e = 0; e < n; e++) begin
      cyc();
      checks++;
      if (d_vec !== m_vec) begin errors++; $display("FAIL idle_model: got %h want %h", d_vec, m_vec); end
    end
  endtask

  task automatic test_reset();
    logic [3*W:0] exp;
    async_in = '1;
    rstB = 1'b1;
    repeat (3) begin
      cyc();
      checks++;
      if (d_vec !== '0) begin errors++; $display("FAIL reset_hold: got %h want 0", d_vec); end
    end
    rstB = 1'b0;
    for (int e = 1; e <= LAT + 2; e++) begin
      cyc();
      exp = {(e >= LAT) ? {W{1'b1}} : {W{1'b0}}, (e == LAT) ? {W{1'b1}} : {W{1'b0}}, {W{1'b0}}, 1'(e == LAT)};
      checks++;
      if (d_vec !== exp) begin errors++; $display("FAIL reset_release e=%0d: got %h want %h", e, d_vec, exp); end
      checks++;
      if (d_vec !== m_vec) begin errors++; $display("FAIL reset_model e=%0d: got %h want %h", e, d_vec, m_vec); end
    end
  endtask

  task automatic test_latency();
    for (int dir = 1; dir >= 0; dir--) begin
      for (int e = 1; e <= LAT + 2; e++) begin
        async_in[3] = 1'(dir);
        cyc();
        checks++;
        if (sync_out[3] !== 1'(dir == (e >= LAT)) ||
            (dir == 1 ? rise_pulse[3] : fall_pulse[3]) !== 1'(e == LAT) ||
            (dir == 1 ? fall_pulse[3] : rise_pulse[3]) !== 1'b0) begin
          errors++;
          $display("FAIL latency dir=%0d e=%0d: got lvl=%b rise=%b fall=%b", dir, e, sync_out[3], rise_pulse[3], fall_pulse[3]);
        end
        checks++;
        if (d_vec !== m_vec) begin errors++; $display("FAIL latency_model e=%0d: got %h want %h", e, d_vec, m_vec); end
      end
    end
  endtask

  task automatic test_glitch();
    for (int n = F - 1; n <= F; n++) begin
      int rises = 0, falls = 0, rise_e = 0, fall_e = 0;
      if (n == 0) continue;
      for (int e = 1; e <= n + LAT + F + 2; e++) begin
        async_in[0] = 1'(e <= n);
        cyc();
        if (rise_pulse[0]) begin rises++; rise_e = e; end
        if (fall_pulse[0]) begin falls++; fall_e = e; end
        checks++;
        if (d_vec !== m_vec) begin errors++; $display("FAIL glitch_model n=%0d e=%0d: got %h want %h", n, e, d_vec, m_vec); end
      end
      checks++;
      if (rises != int'(n >= F) || falls != int'(n >= F)) begin
        errors++;
        $display("FAIL glitch_count n=%0d: got rises=%0d falls=%0d want %0d", n, rises, falls, int'(n >= F));
      end
      if (n >= F) begin
        checks++;
        if (rise_e != LAT || fall_e - rise_e != n) begin
          errors++;
          $display("FAIL glitch_timing n=%0d: got rise@%0d width=%0d want rise@%0d width=%0d", n, rise_e, fall_e - rise_e, LAT, n);
        end
      end
    end
  endtask

  task automatic test_restart();
    int rises = 0, rise_e = 0;
    for (int e = 1; e <= 2 * F + LAT + 2; e++) begin
      async_in[1] = 1'(e <= F - 1 || (e >= F + 1 && e <= 2 * F));
      cyc();
      if (rise_pulse[1]) begin rises++; rise_e = e; end
      checks++;
      if (d_vec !== m_vec) begin errors++; $display("FAIL restart_model e=%0d: got %h want %h", e, d_vec, m_vec); end
    end
    checks++;
    if (rises != 1 || rise_e != F + LAT) begin
      errors++;
      $display("FAIL restart: got rises=%0d at %0d want 1 at %0d", rises, rise_e, F + LAT);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0, first_e = 0, last_e = 0;
    for (int e = 1; e <= 6 * F + LAT + 2; e++) begin
      async_in[2] = 1'(((e - 1) / F) % 2 == 0 && e <= 6 * F);
      cyc();
      if (rise_pulse[2] || fall_pulse[2]) begin
        pulses++;
        if (first_e == 0) first_e = e;
        last_e = e;
      end
      checks++;
      if (d_vec !== m_vec) begin errors++; $display("FAIL b2b_model e=%0d: got %h want %h", e, d_vec, m_vec); end
    end
    checks++;
    if (pulses != 6 || first_e != LAT || last_e != LAT + 5 * F) begin
      errors++;
      $display("FAIL back_to_back: got %0d pulses first=%0d last=%0d want 6 first=%0d last=%0d", pulses, first_e, last_e, LAT, LAT + 5 * F);
    end
  endtask

  task automatic test_mid_reset();
    for (int e = 1; e <= S + 2; e++) begin
      async_in[5] = 1'b1;
      cyc();
      checks++;
      if (d_vec !== m_vec) begin errors++; $display("FAIL midrst_model e=%0d: got %h want %h", e, d_vec, m_vec); end
    end
    rstB = 1'b1;
    cyc();
    rstB = 1'b0;
    checks++;
    if (d_vec !== {{W{RV}}, {(2 * W + 1){1'b0}}}) begin errors++; $display("FAIL midrst_reset: got %h want %h", d_vec, {{W{RV}}, {(2 * W + 1){1'b0}}}); end
    for (int e = 1; e <= LAT + 2; e++) begin
      cyc();
      checks++;
      if (sync_out[5] !== 1'(e >= LAT) || rise_pulse[5] !== 1'(e == LAT) || any_change !== 1'(e == LAT)) begin
        errors++;
        $display("FAIL midrst_relatency e=%0d: got lvl=%b rise=%b any=%b", e, sync_out[5], rise_pulse[5], any_change);
      end
      checks++;
      if (d_vec !== m_vec) begin errors++; $display("FAIL midrst_model2 e=%0d: got %h want %h", e, d_vec, m_vec); end
    end
  endtask

  task automatic test_random();
    for (int e = 0; e < 800; e++) begin
      async_in = async_in ^ W'($urandom & $urandom);
      rstB = ($urandom_range(0, 79) == 0);
      cyc();
      checks++;
      if (d_vec !== m_vec) begin errors++; $display("FAIL random_model e=%0d: got %h want %h", e, d_vec, m_vec); end
    end
    rstB = 1'b0;
  endtask

  initial begin
    rstB = 1'b1;
    async_in = '1;
    test_reset();
    test_idle(LAT + 4);
    test_latency();
    test_idle(LAT + 4);
    test_glitch();
    test_idle(LAT + 4);
    test_restart();
    test_idle(LAT + 4);
    test_back_to_back();
    test_idle(LAT + 4);
    test_mid_reset();
    test_idle(LAT + 4);
    test_random();
    test_idle(LAT + 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
